mining_job_issuer: RTL and testbench

Initiator side of the T81 SHA3 mining pipeline command interface. It buffers opcode/operand jobs from the host, replays them onto the `mining_pipeline` command port with the standard one-cycle `valid_opcode` strobe and inter-command gap, and fires `start_mine` on a job marked last. It then watches `match_found` under a timeout and returns a result record to the host through a valid/ready handshake. It sits between the host job source and `mining_pipeline`, in place of the directed bench driver.

---
 rtl/mining_job_issuer.sv | 192 +++++++++++++++++++
 tb/tb_mining_job_issuer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mining_job_issuer.sv
// mining_job_issuer: buffers host jobs, replays them onto the mining_pipeline
// command port as one-cycle strobes separated by a fixed gap, starts mining on
// a job marked last, then waits for a match under a timeout. The result goes
// back to the host over a valid/ready handshake.
//
// Handshakes: a job transfers on a rising edge where job_valid && job_ready.
// A result transfers on a rising edge where res_valid && res_ready. Once
// res_valid rises, it and res_match/res_timeout/res_cycles hold until that
// edge or an abort.
module mining_job_issuer #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [7:0]  job_opcode,
  input  logic [80:0] job_operand,
  input  logic        job_last,
  input  logic        abort,
  output logic [7:0]  opcode,
  output logic [80:0] operand,
  output logic        valid_opcode,
  output logic        start_mine,
  input  logic        match_found,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_match,
  output logic        res_timeout,
  output logic [15:0] res_cycles,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_MINE   = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  logic [7:0]    r_mem_op      [DEPTH];
  logic [80:0]   r_mem_operand [DEPTH];
  logic          r_mem_last    [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [2:0]    r_state;
  logic [GW-1:0] r_gap_cnt;
  logic [15:0]   r_cnt;
  logic          r_cur_last;
  logic [7:0]    r_opcode;
  logic [80:0]   r_operand;
  logic          r_res_match;
  logic          r_res_timeout;
  logic [15:0]   r_res_cycles;

  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_gap_done;

  // FIFO occupancy, push/pop qualification; abort discards a coincident push.
  always_comb begin
    w_count    = r_wr_ptr - r_rd_ptr;
    w_full     = w_count[AW];
    w_empty    = (w_count == '0);
    w_push     = job_valid && !w_full && !abort;
    w_gap_done = (r_state == S_GAP) && (r_gap_cnt == GW'(GAP_CYCLES - 1));
    w_pop      = !abort && !w_empty &&
                 ((r_state == S_IDLE) || (w_gap_done && !r_cur_last));
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_op[r_wr_ptr[AW-1:0]]      <= job_opcode;
      r_mem_operand[r_wr_ptr[AW-1:0]] <= job_operand;
      r_mem_last[r_wr_ptr[AW-1:0]]    <= job_last;
    end
  end

  // FIFO pointers; abort empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Issue/mine/report sequencer with command and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_gap_cnt     <= '0;
      r_cnt         <= '0;
      r_cur_last    <= 1'b0;
      r_opcode      <= '0;
      r_operand     <= '0;
      r_res_match   <= 1'b0;
      r_res_timeout <= 1'b0;
      r_res_cycles  <= '0;
    end else if (abort) begin
      r_state       <= S_IDLE;
      r_gap_cnt     <= '0;
      r_cnt         <= '0;
      r_res_match   <= 1'b0;
      r_res_timeout <= 1'b0;
      r_res_cycles  <= '0;
    end else begin
      if (w_pop) begin
        r_opcode   <= r_mem_op[r_rd_ptr[AW-1:0]];
        r_operand  <= r_mem_operand[r_rd_ptr[AW-1:0]];
        r_cur_last <= r_mem_last[r_rd_ptr[AW-1:0]];
      end
      case (r_state)
        S_IDLE: begin
          if (w_pop) r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_gap_cnt <= '0;
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (w_gap_done) begin
            r_gap_cnt <= '0;
            if (r_cur_last)  r_state <= S_MINE;
            else if (w_pop)  r_state <= S_ISSUE;
            else             r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        S_MINE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A match on the final cycle beats the timeout.
          if (match_found) begin
            r_res_match  <= 1'b1;
            r_res_cycles <= r_cnt + 16'd1;
            r_state      <= S_REPORT;
          end else if (r_cnt == 16'(TIMEOUT - 1)) begin
            r_res_timeout <= 1'b1;
            r_res_cycles  <= 16'(TIMEOUT);
            r_state       <= S_REPORT;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            r_res_match   <= 1'b0;
            r_res_timeout <= 1'b0;
            r_res_cycles  <= '0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so async reset clears them at once.
  always_comb begin
    job_ready    = !w_full;
    opcode       = r_opcode;
    operand      = r_operand;
    valid_opcode = (r_state == S_ISSUE);
    start_mine   = (r_state == S_MINE);
    res_valid    = (r_state == S_REPORT);
    res_match    = r_res_match;
    res_timeout  = r_res_timeout;
    res_cycles   = r_res_cycles;
    busy         = (r_state != S_IDLE) || !w_empty;
    dbg_state    = r_state;
  end

endmodule

// File: tb/tb_mining_job_issuer.sv
// Bench for mining_job_issuer: directed jobs, expected commands and results
// queued at stimulus time, a negedge monitor pops and compares them.
module tb_mining_job_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [7:0]  job_opcode = '0;
  logic [80:0] job_operand = '0;
  logic        job_last = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  opcode;
  logic [80:0] operand;
  logic        valid_opcode;
  logic        start_mine;
  logic        match_found = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_match;
  logic        res_timeout;
  logic [15:0] res_cycles;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [88:0] exp_cmd_q[$];
  logic [17:0] exp_res_q[$];
  int          strobe_cyc[$];
  int          mine_cyc = 0;
  int          resv_cyc = 0;
  int          resv_count = 0;
  logic        prev_res_valid = 1'b0;

  mining_job_issuer #(.DEPTH(4), .GAP_CYCLES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_opcode(job_opcode),
    .job_operand(job_operand), .job_last(job_last), .abort(abort),
    .opcode(opcode), .operand(operand), .valid_opcode(valid_opcode),
    .start_mine(start_mine), .match_found(match_found),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .res_timeout(res_timeout), .res_cycles(res_cycles), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_opcode) begin
        strobe_cyc.push_back(cyc);
        n_checks++;
        if (exp_cmd_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_strobe: got op=%0h operand=%0h expected none", opcode, operand);
        end else begin
          logic [88:0] e;
          e = exp_cmd_q.pop_front();
          if ({opcode, operand} !== e) begin
            n_errors++;
            $display("FAIL cmd: got %0h expected %0h", {opcode, operand}, e);
          end
        end
      end
      if (start_mine) mine_cyc = cyc;
      if (res_valid && !prev_res_valid) begin
        resv_cyc = cyc;
        resv_count++;
      end
      prev_res_valid = res_valid;
      if (res_valid && res_ready) begin
        n_checks++;
        if (exp_res_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_result: got %0h expected none", {res_match, res_timeout, res_cycles});
        end else begin
          logic [17:0] r;
          r = exp_res_q.pop_front();
          if ({res_match, res_timeout, res_cycles} !== r) begin
            n_errors++;
            $display("FAIL result: got %0h expected %0h", {res_match, res_timeout, res_cycles}, r);
          end
        end
      end
    end else begin
      prev_res_valid = 1'b0;
    end
  end

  // driver: offer one job, wait (bounded) for acceptance
  task automatic push_job(input logic [7:0] op, input logic [80:0] opnd, input logic last,
                          input logic expect_issue, output int push_cyc);
    int k;
    @(negedge clk);
    job_valid = 1'b1; job_opcode = op; job_operand = opnd; job_last = last;
    k = 0;
    while (!job_ready && k < 100) begin @(negedge clk); k++; end
    check("push_ready", job_ready, 1);
    if (expect_issue) exp_cmd_q.push_back({op, opnd});
    @(posedge clk); #1;
    push_cyc = cyc;
    job_valid = 1'b0;
  endtask

  // driver: offer a job that must be refused
  task automatic push_rejected(input logic [7:0] op);
    @(negedge clk);
    job_valid = 1'b1; job_opcode = op; job_operand = 81'h5; job_last = 1'b0;
    check("fifo_full_ready", job_ready, 0);
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_start_mine();
    int k;
    k = 0;
    while (!start_mine && k < 200) begin @(negedge clk); k++; end
    check("start_mine_seen", start_mine, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || res_valid || exp_cmd_q.size() != 0) && k < 200) begin @(negedge clk); k++; end
    check("reach_idle", busy, 0);
  endtask

  initial begin
    int pc;
    int n0;
    logic [80:0] rnd;

    // reset
    repeat (3) @(negedge clk);
    check("rst_job_ready", job_ready, 1);
    check("rst_strobes", {valid_opcode, start_mine}, 0);
    check("rst_res", {res_valid, res_match, res_timeout, res_cycles}, 0);
    check("rst_cmd", {opcode, operand}, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_no_strobe", strobe_cyc.size(), 0);

    // command sequence and match
    rnd = {$urandom, $urandom, $urandom};
    push_job(8'h01, 81'hABC, 1'b0, 1'b1, pc);
    push_job(8'h02, 81'h123, 1'b0, 1'b1, n0);
    push_job(8'h10, rnd, 1'b1, 1'b1, n0);
    exp_res_q.push_back({1'b1, 1'b0, 16'd6});
    wait_start_mine();
    @(posedge clk);                 // first WAIT cycle (count 0)
    repeat (5) @(posedge clk);      // sixth WAIT cycle (count 5)
    #1 match_found = 1'b1;
    @(posedge clk); #1 match_found = 1'b0;
    check("seq_strobe_count", strobe_cyc.size(), 3);
    check("first_cmd_latency", strobe_cyc[0] - pc, 1);
    check("strobe_spacing_1", strobe_cyc[1] - strobe_cyc[0], 3);
    check("strobe_spacing_2", strobe_cyc[2] - strobe_cyc[1], 3);
    check("start_mine_delay", mine_cyc - strobe_cyc[2], 3);
    wait_idle();

    // timeout
    push_job(8'h20, 81'h1_0000_0000_0000_0042, 1'b1, 1'b1, n0);
    exp_res_q.push_back({1'b0, 1'b1, 16'd16});
    wait_start_mine();
    wait_idle();
    check("timeout_resv_rise", resv_cyc - mine_cyc, 17);

    // match on final WAIT cycle, then backpressure and FIFO full
    res_ready = 1'b0;
    push_job(8'h30, 81'h777, 1'b1, 1'b1, n0);
    exp_res_q.push_back({1'b1, 1'b0, 16'd16});
    wait_start_mine();
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1 match_found = 1'b1;
    @(posedge clk); #1 match_found = 1'b0;
    n0 = strobe_cyc.size();
    push_job(8'h41, 81'h41, 1'b0, 1'b1, pc);
    push_job(8'h42, 81'h42, 1'b0, 1'b1, pc);
    push_job(8'h43, 81'h43, 1'b0, 1'b1, pc);
    push_job(8'h44, 81'h44, 1'b0, 1'b1, pc);
    push_rejected(8'h45);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_res", {res_valid, res_match, res_timeout, res_cycles}, {1'b1, 1'b1, 1'b0, 16'd16});
    end
    check("hold_no_issue", strobe_cyc.size(), n0);
    check("hold_busy", busy, 1);
    @(posedge clk); #1 res_ready = 1'b1;
    wait_idle();
    check("full_issue_count", strobe_cyc.size() - n0, 4);
    check("full_spacing", strobe_cyc[n0 + 3] - strobe_cyc[n0 + 2], 3);

    // abort mid-WAIT with two jobs queued
    push_job(8'h50, 81'h50, 1'b1, 1'b1, n0);
    wait_start_mine();
    push_job(8'h51, 81'h51, 1'b0, 1'b0, n0);
    push_job(8'h52, 81'h52, 1'b0, 1'b0, n0);
    n0 = resv_count;
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_ready", job_ready, 1);
    check("abort_res", {res_valid, res_match, res_timeout, res_cycles, start_mine}, 0);
    #1 match_found = 1'b1;
    @(posedge clk); #1 match_found = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_result", resv_count - n0, 0);
    check("abort_still_idle", busy, 0);

    // asynchronous reset mid-WAIT
    push_job(8'h60, 81'h60, 1'b1, 1'b1, n0);
    wait_start_mine();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out", {start_mine, res_valid, res_match, res_timeout, res_cycles}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("cmd_queue_drained", exp_cmd_q.size(), 0);
    check("res_queue_drained", exp_res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
